// File: rtl/lzc_normalizer.sv
// Two-stage normalisation pipeline behind a leading-zero counter.
// Stage 1 captures the mantissa and exponent and resolves the shift amount,
// the zero flag and underflow. Stage 2 applies the shift and adjusts the exponent.
// Both stages use a valid/ready handshake that forwards backpressure.
module lzc_normalizer #(
    parameter int WIDTH = 16,
    parameter int COUNT = $clog2(WIDTH),
    parameter int EXP_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [COUNT:0]   lz_cnt,
    input  logic             lz_nz,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_uf
);

    localparam int CW = COUNT + 1;
    // Wide enough to compare the exponent and the shift without losing bits.
    localparam int XW = EXP_W + COUNT;
    localparam logic [CW-1:0]    LZ_SAT = CW'(WIDTH);
    localparam logic [COUNT-1:0] SH_MAX = COUNT'(WIDTH - 1);

    // Stage 1 registers
    logic             s1_v_q, s1_v_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d;
    logic [COUNT-1:0] s1_eff_q, s1_eff_d;
    logic             s1_zero_q, s1_zero_d;
    logic             s1_uf_q, s1_uf_d;

    // Stage 2 registers
    logic             s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s2_data_q, s2_data_d;
    logic [EXP_W-1:0] s2_exp_q, s2_exp_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_uf_q, s2_uf_d;

    logic             s1_ready, s2_ready, in_fire;
    logic [COUNT-1:0] sh_c, eff_c;
    logic [XW-1:0]    exp_x, sh_x;
    logic             uf_c;

    assign s2_ready = !s2_v_q || out_ready;
    assign s1_ready = !s1_v_q || s2_ready;
    assign in_ready = rst_n && s1_ready;
    assign in_fire  = in_valid && in_ready;

    // Shift amount: clamp the count, then limit the shift to the exponent on underflow
    always_comb begin
        sh_c  = (lz_cnt >= LZ_SAT) ? SH_MAX : lz_cnt[COUNT-1:0];
        exp_x = XW'(in_exp);
        sh_x  = XW'(sh_c);
        uf_c  = lz_nz && (exp_x < sh_x);
        eff_c = '0;
        if (lz_nz) begin
            eff_c = uf_c ? exp_x[COUNT-1:0] : sh_c;
        end
    end

    // Stage 1 next state: refill whenever the slot is empty or being drained
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_data_d = s1_data_q;
        s1_exp_d  = s1_exp_q;
        s1_eff_d  = s1_eff_q;
        s1_zero_d = s1_zero_q;
        s1_uf_d   = s1_uf_q;
        if (s1_ready) begin
            s1_v_d = in_valid;
        end
        if (in_fire) begin
            s1_data_d = in_data;
            s1_exp_d  = in_exp;
            s1_eff_d  = eff_c;
            s1_zero_d = !lz_nz;
            s1_uf_d   = uf_c;
        end
    end

    // Stage 2 next state: apply the shift and exponent adjustment when stage 1 advances
    always_comb begin
        s2_v_d    = s2_v_q;
        s2_data_d = s2_data_q;
        s2_exp_d  = s2_exp_q;
        s2_zero_d = s2_zero_q;
        s2_uf_d   = s2_uf_q;
        if (s2_ready) begin
            s2_v_d = s1_v_q;
        end
        if (s1_v_q && s2_ready) begin
            if (s1_zero_q) begin
                s2_data_d = '0;
                s2_exp_d  = '0;
                s2_zero_d = 1'b1;
                s2_uf_d   = 1'b0;
            end else begin
                s2_data_d = s1_data_q << s1_eff_q;
                s2_exp_d  = s1_exp_q - EXP_W'(s1_eff_q);
                s2_zero_d = 1'b0;
                s2_uf_d   = s1_uf_q;
            end
        end
    end

    // Pipeline registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_data_q <= '0;
            s1_exp_q  <= '0;
            s1_eff_q  <= '0;
            s1_zero_q <= 1'b0;
            s1_uf_q   <= 1'b0;
            s2_v_q    <= 1'b0;
            s2_data_q <= '0;
            s2_exp_q  <= '0;
            s2_zero_q <= 1'b0;
            s2_uf_q   <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_data_q <= s1_data_d;
            s1_exp_q  <= s1_exp_d;
            s1_eff_q  <= s1_eff_d;
            s1_zero_q <= s1_zero_d;
            s1_uf_q   <= s1_uf_d;
            s2_v_q    <= s2_v_d;
            s2_data_q <= s2_data_d;
            s2_exp_q  <= s2_exp_d;
            s2_zero_q <= s2_zero_d;
            s2_uf_q   <= s2_uf_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out_data  = s2_data_q;
    assign out_exp   = s2_exp_q;
    assign out_zero  = s2_zero_q;
    assign out_uf    = s2_uf_q;

endmodule

// File: tb/tb_lzc_normalizer.sv
// Bench for lzc_normalizer (WIDTH=16, EXP_W=8). It runs directed cases, a
// backpressure scenario, a mid-flight reset and randomized traffic. All
// results are checked against a queue-based reference model.
module tb_lzc_normalizer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [7:0]  in_exp;
    logic [4:0]  lz_cnt;
    logic        lz_nz;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [7:0]  out_exp;
    logic        out_zero;
    logic        out_uf;

    typedef struct packed {
        logic [15:0] d;
        logic [7:0]  e;
        logic        z;
        logic        u;
    } res_t;

    res_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   last_acc;
    bit   last_pop;

    lzc_normalizer #(.WIDTH(16), .EXP_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_exp    (in_exp),
        .lz_cnt    (lz_cnt),
        .lz_nz     (lz_nz),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_exp   (out_exp),
        .out_zero  (out_zero),
        .out_uf    (out_uf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: normalise by the clamped count; underflow limits the shift to the exponent.
    function automatic res_t model(input logic [15:0] d, input logic [4:0] lz,
                                   input logic nz, input logic [7:0] e);
        res_t        r;
        int          sh;
        logic [31:0] t;
        r = '0;
        if (!nz) begin
            r.z = 1'b1;
            return r;
        end
        sh = (int'(lz) > 15) ? 15 : int'(lz);
        if (int'(e) < sh) begin
            t   = {16'd0, d} << e;
            r.u = 1'b1;
            r.e = 8'd0;
        end else begin
            t   = {16'd0, d} << sh;
            r.e = 8'(int'(e) - sh);
        end
        r.d = t[15:0];
        return r;
    endfunction

    task automatic rand_beat();
        int cnt;
        bit found;
        int kind;
        kind    = $urandom_range(0, 9);
        in_data = 16'($urandom) >> $urandom_range(0, 16);
        cnt     = 0;
        found   = 0;
        for (int i = 15; i >= 0; i--) begin
            if (in_data[i]) found = 1;
            if (!found) cnt++;
        end
        lz_nz  = (in_data != 16'd0);
        lz_cnt = lz_nz ? 5'(cnt) : 5'($urandom_range(0, 16));
        if (kind == 0) begin
            lz_nz  = 1'b1;
            lz_cnt = 5'd16;
            if (in_data == 16'd0) in_data = 16'h0003;
        end else if (kind == 1) begin
            in_data = 16'd0;
            lz_nz   = 1'b0;
            lz_cnt  = 5'($urandom_range(0, 16));
        end
        in_exp = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 20))
                                             : 8'($urandom_range(0, 255));
    endtask

    // One clock of scoreboarded traffic; called just after a falling edge with inputs driven.
    task automatic cycle();
        #1;
        check("in_ready", 32'(in_ready), 32'(rst_n && (q.size() < 2 || out_ready)));
        check("no_spurious", 32'(out_valid && q.size() == 0), 32'd0);
        if (out_valid && q.size() > 0) begin
            check("out_data", 32'(out_data), 32'(q[0].d));
            check("out_exp",  32'(out_exp),  32'(q[0].e));
            check("out_zero", 32'(out_zero), 32'(q[0].z));
            check("out_uf",   32'(out_uf),   32'(q[0].u));
        end
        last_acc = 0;
        last_pop = 0;
        if (rst_n) begin
            if (out_valid && out_ready && q.size() > 0) begin
                void'(q.pop_front());
                last_pop = 1;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(in_data, lz_cnt, lz_nz, in_exp));
                last_acc = 1;
            end
        end
        @(posedge clk);
        if (!rst_n) q.delete();
        @(negedge clk);
    endtask

    // Single beat on an idle pipeline with spec-given expectations and 2-cycle latency.
    task automatic directed(input string tag, input logic [15:0] d, input logic [4:0] lz,
                            input logic nz, input logic [7:0] e, input logic [15:0] xd,
                            input logic [7:0] xe, input logic xz, input logic xu);
        in_valid  = 1'b1;
        in_data   = d;
        lz_cnt    = lz;
        lz_nz     = nz;
        in_exp    = e;
        out_ready = 1'b1;
        #1;
        check({tag, "_accept"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, "_lat1"}, 32'(out_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"},  32'(out_data),  32'(xd));
        check({tag, "_exp"},   32'(out_exp),   32'(xe));
        check({tag, "_zero"},  32'(out_zero),  32'(xz));
        check({tag, "_uf"},    32'(out_uf),    32'(xu));
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int  sent;
        int  got;
        int  stall;
        bit  seen;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_exp    = '0;
        lz_cnt    = '0;
        lz_nz     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_exp",   32'(out_exp),   32'd0);
        check("rst_out_zero",  32'(out_zero),  32'd0);
        check("rst_out_uf",    32'(out_uf),    32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        directed("basic",    16'h0F00, 5'd4,  1'b1, 8'd20,  16'hF000, 8'd16, 1'b0, 1'b0);
        directed("uflow",    16'h0001, 5'd15, 1'b1, 8'd10,  16'h0400, 8'd0,  1'b0, 1'b1);
        directed("zero",     16'h0000, 5'd16, 1'b0, 8'd50,  16'h0000, 8'd0,  1'b1, 1'b0);
        directed("boundary", 16'h00FF, 5'd8,  1'b1, 8'd8,   16'hFF00, 8'd0,  1'b0, 1'b0);
        directed("clamp",    16'h0003, 5'd16, 1'b1, 8'd100, 16'h8000, 8'd85, 1'b0, 1'b0);

        // Backpressure: four beats, downstream stalls three cycles at first output.
        sent  = 0;
        got   = 0;
        stall = 0;
        seen  = 0;
        for (int c = 0; c < 40 && (sent < 4 || q.size() > 0); c++) begin
            if (out_valid && !seen) begin
                seen  = 1;
                stall = 3;
            end
            out_ready = (stall == 0);
            if (stall > 0) stall--;
            in_valid = (sent < 4);
            in_data  = 16'h0F00;
            lz_cnt   = 5'd4;
            lz_nz    = 1'b1;
            in_exp   = 8'(40 + sent);
            cycle();
            if (last_acc) sent++;
            if (last_pop) got++;
        end
        in_valid = 1'b0;
        check("bp_received", 32'(got), 32'd4);
        check("bp_empty", 32'(q.size()), 32'd0);

        // Reset with both stages full.
        out_ready = 1'b0;
        for (int c = 0; c < 10 && q.size() < 2; c++) begin
            in_valid = 1'b1;
            rand_beat();
            cycle();
        end
        check("mid_fill", 32'(q.size()), 32'd2);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd0);
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 16'h0030;
        lz_cnt    = 5'd10;
        lz_nz     = 1'b1;
        in_exp    = 8'd77;
        cycle();
        in_valid = 1'b0;
        repeat (3) cycle();
        check("mid_first_out", 32'(q.size()), 32'd0);

        // Randomized traffic with random handshakes and occasional reset.
        for (int c = 0; c < 600; c++) begin
            rst_n     = ($urandom_range(0, 99) != 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            rand_beat();
            cycle();
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && q.size() > 0; c++) cycle();
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
